// File: rtl/regfile_arb_pkg.sv
// Shared types and widths for the register-file writeback arbiter.
// Used by regfile_write_arbiter and wb_slot.
package regfile_arb_pkg;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;

  typedef enum logic {
    REQ_A = 1'b0,
    REQ_M = 1'b1
  } req_id_t;

  typedef struct packed {
    logic              valid;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wb_slot_t;

endpackage

// File: rtl/wb_slot.sv
// One-entry writeback holding register.
// Load wins over drain so a draining slot can refill in the same cycle.
module wb_slot
  import regfile_arb_pkg::*;
(
  input  logic              Clock,
  input  logic              flush,
  input  logic              load,
  input  logic              drain,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [DATA_W-1:0] load_data,
  output logic              slot_valid,
  output logic [ADDR_W-1:0] slot_addr,
  output logic [DATA_W-1:0] slot_data
);

  wb_slot_t q;

  always_ff @(posedge Clock) begin
    if (flush) begin
      q <= '0;
    end else if (load) begin
      q.valid <= 1'b1;
      q.addr  <= load_addr;
      q.data  <= load_data;
    end else if (drain) begin
      q.valid <= 1'b0;
    end
  end

  assign slot_valid = q.valid;
  assign slot_addr  = q.addr;
  assign slot_data  = q.data;

endmodule

// File: rtl/regfile_write_arbiter.sv
// Two-requester arbiter for the register file write port.
// Define WB_ARB_RR_EN for round-robin; default is fixed M-over-A.
module regfile_write_arbiter
  import regfile_arb_pkg::*;
(
  input  logic              Clock,
  input  logic              Reset,
  input  logic              Req_valid_a,
  input  logic [ADDR_W-1:0] Req_addr_a,
  input  logic [DATA_W-1:0] Req_data_a,
  output logic              Req_ready_a,
  input  logic              Req_valid_m,
  input  logic [ADDR_W-1:0] Req_addr_m,
  input  logic [DATA_W-1:0] Req_data_m,
  output logic              Req_ready_m,
  output logic              Write_En,
  output logic [ADDR_W-1:0] Write_addr,
  output logic [DATA_W-1:0] Write_data,
  input  logic [ADDR_W-1:0] Lookup_addr,
  output logic              Lookup_hit,
  output logic [DATA_W-1:0] Lookup_data
);

  logic              va;
  logic              vm;
  logic [ADDR_W-1:0] a_addr;
  logic [ADDR_W-1:0] m_addr;
  logic [DATA_W-1:0] a_data;
  logic [DATA_W-1:0] m_data;
  logic              load_a;
  logic              load_m;
  logic              grant_a;
  logic              grant_m;
  logic              same_addr;
  req_id_t           age_q;
  req_id_t           age_d;

`ifdef WB_ARB_RR_EN
  req_id_t ptr_q;

  always_ff @(posedge Clock) begin
    if (Reset)        ptr_q <= REQ_A;
    else if (grant_a) ptr_q <= REQ_M;
    else if (grant_m) ptr_q <= REQ_A;
  end
`endif

  assign Req_ready_a = !Reset && (!va || grant_a);
  assign Req_ready_m = !Reset && (!vm || grant_m);

  // r0 writes complete the handshake but never occupy a slot
  assign load_a = Req_valid_a && Req_ready_a
               && (Req_addr_a != '0);
  assign load_m = Req_valid_m && Req_ready_m
               && (Req_addr_m != '0);

  wb_slot u_slot_a (
    .Clock      (Clock),
    .flush      (Reset),
    .load       (load_a),
    .drain      (grant_a),
    .load_addr  (Req_addr_a),
    .load_data  (Req_data_a),
    .slot_valid (va),
    .slot_addr  (a_addr),
    .slot_data  (a_data)
  );

  wb_slot u_slot_m (
    .Clock      (Clock),
    .flush      (Reset),
    .load       (load_m),
    .drain      (grant_m),
    .load_addr  (Req_addr_m),
    .load_data  (Req_data_m),
    .slot_valid (vm),
    .slot_addr  (m_addr),
    .slot_data  (m_data)
  );

  assign same_addr = (a_addr == m_addr);

  always_comb begin
    grant_a = 1'b0;
    grant_m = 1'b0;
    unique case (1'b1)
      (va && !vm): grant_a = 1'b1;
      (vm && !va): grant_m = 1'b1;
      (va && vm && same_addr): begin
        grant_a = (age_q == REQ_A);
        grant_m = (age_q == REQ_M);
      end
      (va && vm && !same_addr): begin
`ifdef WB_ARB_RR_EN
        grant_a = (ptr_q == REQ_A);
        grant_m = (ptr_q == REQ_M);
`else
        grant_m = 1'b1;
`endif
      end
      default: ;
    endcase
  end

  // Same-cycle double load counts M as older so A's value persists
  always_comb begin
    age_d = age_q;
    unique case (1'b1)
      (load_a && load_m):
        age_d = REQ_M;
      (load_a && !load_m):
        age_d = (vm && !grant_m) ? REQ_M : REQ_A;
      (load_m && !load_a):
        age_d = (va && !grant_a) ? REQ_A : REQ_M;
      (!load_a && !load_m && grant_a):
        age_d = REQ_M;
      (!load_a && !load_m && grant_m):
        age_d = REQ_A;
      default: ;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) age_q <= REQ_A;
    else       age_q <= age_d;
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      Write_En   <= 1'b0;
      Write_addr <= '0;
      Write_data <= '0;
    end else if (grant_a) begin
      Write_En   <= 1'b1;
      Write_addr <= a_addr;
      Write_data <= a_data;
    end else if (grant_m) begin
      Write_En   <= 1'b1;
      Write_addr <= m_addr;
      Write_data <= m_data;
    end else begin
      Write_En   <= 1'b0;
    end
  end

  logic hit_a;
  logic hit_m;
  logic hit_o;
  logic a_younger;

  assign hit_a = va && (a_addr == Lookup_addr);
  assign hit_m = vm && (m_addr == Lookup_addr);
  assign hit_o = Write_En && (Write_addr == Lookup_addr);
  assign a_younger = (age_q == REQ_M) || !hit_m;

  always_comb begin
    Lookup_hit  = 1'b0;
    Lookup_data = '0;
    if (Lookup_addr != '0) begin
      if (hit_a && a_younger) begin
        Lookup_hit  = 1'b1;
        Lookup_data = a_data;
      end else if (hit_m) begin
        Lookup_hit  = 1'b1;
        Lookup_data = m_data;
      end else if (hit_o) begin
        Lookup_hit  = 1'b1;
        Lookup_data = Write_data;
      end
    end
  end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Bench for regfile_write_arbiter: directed scenarios plus random
// traffic against a timestamp-based reference model.
module tb_regfile_write_arbiter;
  import regfile_arb_pkg::*;

  logic              Clock = 1'b0;
  logic              Reset;
  logic              Req_valid_a;
  logic [ADDR_W-1:0] Req_addr_a;
  logic [DATA_W-1:0] Req_data_a;
  logic              Req_ready_a;
  logic              Req_valid_m;
  logic [ADDR_W-1:0] Req_addr_m;
  logic [DATA_W-1:0] Req_data_m;
  logic              Req_ready_m;
  logic              Write_En;
  logic [ADDR_W-1:0] Write_addr;
  logic [DATA_W-1:0] Write_data;
  logic [ADDR_W-1:0] Lookup_addr;
  logic              Lookup_hit;
  logic [DATA_W-1:0] Lookup_data;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 Clock = ~Clock;

  regfile_write_arbiter dut (
    .Clock       (Clock),
    .Reset       (Reset),
    .Req_valid_a (Req_valid_a),
    .Req_addr_a  (Req_addr_a),
    .Req_data_a  (Req_data_a),
    .Req_ready_a (Req_ready_a),
    .Req_valid_m (Req_valid_m),
    .Req_addr_m  (Req_addr_m),
    .Req_data_m  (Req_data_m),
    .Req_ready_m (Req_ready_m),
    .Write_En    (Write_En),
    .Write_addr  (Write_addr),
    .Write_data  (Write_data),
    .Lookup_addr (Lookup_addr),
    .Lookup_hit  (Lookup_hit),
    .Lookup_data (Lookup_data)
  );

  // Reference model: each pending write carries its acceptance cycle
  bit                ma_v, mm_v;
  logic [ADDR_W-1:0] ma_addr, mm_addr;
  logic [DATA_W-1:0] ma_data, mm_data;
  int                ma_t, mm_t;
  bit                ptr_m;
  bit                o_we;
  logic [ADDR_W-1:0] o_addr;
  logic [DATA_W-1:0] o_data;
  int                cyc = 0;

  function automatic bit [1:0] model_grant();
    bit rr;
`ifdef WB_ARB_RR_EN
    rr = 1'b1;
`else
    rr = 1'b0;
`endif
    if (ma_v && mm_v) begin
      if (ma_addr == mm_addr)
        return (ma_t < mm_t) ? 2'b01 : 2'b10;
      if (rr) return ptr_m ? 2'b10 : 2'b01;
      return 2'b10;
    end
    if (ma_v) return 2'b01;
    if (mm_v) return 2'b10;
    return 2'b00;
  endfunction

  function automatic bit m_ready_a();
    bit [1:0] g;
    g = model_grant();
    return !Reset && (!ma_v || g[0]);
  endfunction

  function automatic bit m_ready_m();
    bit [1:0] g;
    g = model_grant();
    return !Reset && (!mm_v || g[1]);
  endfunction

  function automatic logic [DATA_W:0] model_lookup(
    logic [ADDR_W-1:0] q);
    bit found;
    int best;
    logic [DATA_W-1:0] d;
    found = 0;
    best  = -1;
    d     = '0;
    if (q == '0) return '0;
    if (o_we && o_addr == q) begin
      found = 1; best = -1; d = o_data;
    end
    if (mm_v && mm_addr == q && (!found || mm_t > best)) begin
      found = 1; best = mm_t; d = mm_data;
    end
    if (ma_v && ma_addr == q && (!found || ma_t >= best)) begin
      found = 1; best = ma_t; d = ma_data;
    end
    return {found, d};
  endfunction

  task automatic model_step();
    bit [1:0] g;
    bit acc_a, acc_m;
    g = model_grant();
    acc_a = Req_valid_a && m_ready_a();
    acc_m = Req_valid_m && m_ready_m();
    if (Reset) begin
      ma_v = 0; mm_v = 0; ptr_m = 0;
      o_we = 0; o_addr = '0; o_data = '0;
    end else begin
      if (g[0]) begin
        o_we = 1; o_addr = ma_addr; o_data = ma_data;
        ma_v = 0; ptr_m = 1;
      end else if (g[1]) begin
        o_we = 1; o_addr = mm_addr; o_data = mm_data;
        mm_v = 0; ptr_m = 0;
      end else begin
        o_we = 0;
      end
      if (acc_a && Req_addr_a != '0) begin
        ma_v = 1; ma_addr = Req_addr_a;
        ma_data = Req_data_a; ma_t = cyc;
      end
      if (acc_m && Req_addr_m != '0) begin
        mm_v = 1; mm_addr = Req_addr_m;
        mm_data = Req_data_m; mm_t = cyc;
      end
    end
    cyc++;
  endtask

  task automatic tick();
    @(posedge Clock);
    model_step();
    @(negedge Clock);
    #1;
  endtask

  task automatic idle_inputs();
    Req_valid_a = 0; Req_addr_a = '0; Req_data_a = '0;
    Req_valid_m = 0; Req_addr_m = '0; Req_data_m = '0;
  endtask

  task automatic test_reset();
    Reset = 1;
    idle_inputs();
    Lookup_addr = '0;
    tick();
    tick();
    n_checks++;
    if ({Write_En, Write_addr, Write_data} !== '0) begin
      n_fail++;
      $display("FAIL reset_out got=%0d/%0d/%0h exp=0/0/0",
               Write_En, Write_addr, Write_data);
    end
    n_checks++;
    if ({Req_ready_a, Req_ready_m} !== 2'b00) begin
      n_fail++;
      $display("FAIL reset_ready got=%b exp=00",
               {Req_ready_a, Req_ready_m});
    end
    Reset = 0;
    #1;
    n_checks++;
    if ({Req_ready_a, Req_ready_m} !== 2'b11) begin
      n_fail++;
      $display("FAIL post_reset_ready got=%b exp=11",
               {Req_ready_a, Req_ready_m});
    end
  endtask

  task automatic test_single();
    Req_valid_a = 1; Req_addr_a = 5'd1; Req_data_a = 32'd6;
    #1;
    n_checks++;
    if (Req_ready_a !== 1'b1) begin
      n_fail++;
      $display("FAIL single_ready got=%b exp=1", Req_ready_a);
    end
    tick();
    Req_valid_a = 0;
    Lookup_addr = 5'd1;
    #1;
    n_checks++;
    if (Write_En !== 1'b0) begin
      n_fail++;
      $display("FAIL single_early_we got=%b exp=0", Write_En);
    end
    tick();
    n_checks++;
    if ({Write_En, Write_addr, Write_data} !== {1'b1, 5'd1, 32'd6}) begin
      n_fail++;
      $display("FAIL single_write got=%0d/%0d/%0h exp=1/1/6",
               Write_En, Write_addr, Write_data);
    end
    n_checks++;
    if (Req_ready_m !== 1'b1) begin
      n_fail++;
      $display("FAIL single_ready_m got=%b exp=1", Req_ready_m);
    end
    n_checks++;
    if ({Lookup_hit, Lookup_data} !== {1'b1, 32'd6}) begin
      n_fail++;
      $display("FAIL single_lookup got=%b/%0h exp=1/6",
               Lookup_hit, Lookup_data);
    end
    tick();
    n_checks++;
    if (Write_En !== 1'b0) begin
      n_fail++;
      $display("FAIL single_drop got=%b exp=0", Write_En);
    end
  endtask

  // Pointer sits on M here (A was granted last), so M goes first either way
  task automatic test_same_cycle();
    Req_valid_a = 1; Req_addr_a = 5'd3; Req_data_a = 32'd7;
    Req_valid_m = 1; Req_addr_m = 5'd4; Req_data_m = 32'd9;
    tick();
    idle_inputs();
    tick();
    n_checks++;
    if ({Write_En, Write_addr, Write_data} !== {1'b1, 5'd4, 32'd9}) begin
      n_fail++;
      $display("FAIL pair_first got=%0d/%0d/%0h exp=1/4/9",
               Write_En, Write_addr, Write_data);
    end
    tick();
    n_checks++;
    if ({Write_En, Write_addr, Write_data} !== {1'b1, 5'd3, 32'd7}) begin
      n_fail++;
      $display("FAIL pair_second got=%0d/%0d/%0h exp=1/3/7",
               Write_En, Write_addr, Write_data);
    end
    tick();
  endtask

  task automatic test_r0();
    Req_valid_a = 1; Req_addr_a = 5'd0; Req_data_a = 32'd7;
    Lookup_addr = 5'd0;
    #1;
    n_checks++;
    if (Req_ready_a !== 1'b1) begin
      n_fail++;
      $display("FAIL r0_ready got=%b exp=1", Req_ready_a);
    end
    tick();
    idle_inputs();
    tick();
    n_checks++;
    if (Write_En !== 1'b0) begin
      n_fail++;
      $display("FAIL r0_we got=%b exp=0", Write_En);
    end
    n_checks++;
    if ({Lookup_hit, Lookup_data} !== '0) begin
      n_fail++;
      $display("FAIL r0_lookup got=%b/%0h exp=0/0",
               Lookup_hit, Lookup_data);
    end
  endtask

  task automatic test_age_override();
    Req_valid_a = 1; Req_addr_a = 5'd5; Req_data_a = 32'd1;
    Req_valid_m = 1; Req_addr_m = 5'd6; Req_data_m = 32'h11;
    Lookup_addr = 5'd5;
    tick();
    Req_valid_a = 0;
    Req_addr_m = 5'd5; Req_data_m = 32'd2;
    #1;
    n_checks++;
    if ({Req_ready_a, Req_ready_m} !== 2'b01) begin
      n_fail++;
      $display("FAIL age_ready got=%b exp=01",
               {Req_ready_a, Req_ready_m});
    end
    tick();
    idle_inputs();
    #1;
    n_checks++;
    if ({Write_addr, Lookup_hit, Lookup_data} !== {5'd6, 1'b1, 32'd2}) begin
      n_fail++;
      $display("FAIL age_pending got=%0d/%b/%0h exp=6/1/2",
               Write_addr, Lookup_hit, Lookup_data);
    end
    tick();
    n_checks++;
    if ({Write_En, Write_addr, Write_data} !== {1'b1, 5'd5, 32'd1}) begin
      n_fail++;
      $display("FAIL age_older got=%0d/%0d/%0h exp=1/5/1",
               Write_En, Write_addr, Write_data);
    end
    tick();
    n_checks++;
    if ({Write_En, Write_addr, Write_data} !== {1'b1, 5'd5, 32'd2}) begin
      n_fail++;
      $display("FAIL age_younger got=%0d/%0d/%0h exp=1/5/2",
               Write_En, Write_addr, Write_data);
    end
    n_checks++;
    if ({Lookup_hit, Lookup_data} !== {1'b1, 32'd2}) begin
      n_fail++;
      $display("FAIL age_lookup_out got=%b/%0h exp=1/2",
               Lookup_hit, Lookup_data);
    end
    tick();
  endtask

  task automatic test_stream();
    int  cnt_a, cnt_m, beat_a, beat_m;
    bit  ra, rm, last_a, have_last, exp_alt;
    cnt_a = 0; cnt_m = 0; beat_a = 0; beat_m = 0;
    have_last = 0; last_a = 0;
`ifdef WB_ARB_RR_EN
    exp_alt = 1;
`else
    exp_alt = 0;
`endif
    Req_valid_a = 1; Req_addr_a = 5'd1; Req_data_a = $urandom;
    Req_valid_m = 1; Req_addr_m = 5'd16; Req_data_m = $urandom;
    #1;
    ra = m_ready_a(); rm = m_ready_m();
    tick();
    for (int k = 0; k <= 8; k++) begin
      if (k > 0) begin
        n_checks++;
        if (Write_En !== 1'b1) begin
          n_fail++;
          $display("FAIL stream_we k=%0d got=%b exp=1", k, Write_En);
        end
        if (Write_En === 1'b1 && Write_addr < 5'd16) cnt_a++;
        if (Write_En === 1'b1 && Write_addr >= 5'd16) cnt_m++;
        if (exp_alt && have_last) begin
          n_checks++;
          if ((Write_addr < 5'd16) === last_a) begin
            n_fail++;
            $display("FAIL stream_alt k=%0d got=%0d prev_a=%b",
                     k, Write_addr, last_a);
          end
        end
        last_a = (Write_addr < 5'd16);
        have_last = 1;
      end
      if (k == 8) break;
      if (ra) begin
        beat_a++;
        Req_addr_a = 5'(1 + beat_a % 15);
        Req_data_a = $urandom;
      end
      if (rm) begin
        beat_m++;
        Req_addr_m = 5'(16 + beat_m % 16);
        Req_data_m = $urandom;
      end
      #1;
      if (!exp_alt) begin
        n_checks++;
        if (Req_ready_a !== 1'b0) begin
          n_fail++;
          $display("FAIL stream_starve k=%0d got=%b exp=0",
                   k, Req_ready_a);
        end
      end
      ra = m_ready_a(); rm = m_ready_m();
      tick();
    end
    n_checks++;
    if (exp_alt ? (cnt_a !== 4 || cnt_m !== 4)
                : (cnt_a !== 0 || cnt_m !== 8)) begin
      n_fail++;
      $display("FAIL stream_count got=%0d/%0d exp=%0d/%0d",
               cnt_a, cnt_m, exp_alt ? 4 : 0, exp_alt ? 4 : 8);
    end
    idle_inputs();
    tick(); tick(); tick();
  endtask

  task automatic test_reset_mid();
    Req_valid_a = 1; Req_addr_a = 5'd7; Req_data_a = 32'h70;
    Req_valid_m = 1; Req_addr_m = 5'd8; Req_data_m = 32'h80;
    tick();
    idle_inputs();
    Reset = 1;
    Lookup_addr = 5'd7;
    #1;
    n_checks++;
    if ({Req_ready_a, Req_ready_m} !== 2'b00) begin
      n_fail++;
      $display("FAIL mid_reset_ready got=%b exp=00",
               {Req_ready_a, Req_ready_m});
    end
    tick();
    n_checks++;
    if (Write_En !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_reset_we got=%b exp=0", Write_En);
    end
    n_checks++;
    if (Lookup_hit !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_reset_look7 got=%b exp=0", Lookup_hit);
    end
    Lookup_addr = 5'd8;
    #1;
    n_checks++;
    if (Lookup_hit !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_reset_look8 got=%b exp=0", Lookup_hit);
    end
    Reset = 0;
    tick();
  endtask

  task automatic test_random();
    logic [DATA_W:0] exp_l;
    for (int i = 0; i < 400; i++) begin
      Reset = ($urandom_range(0, 49) == 0);
      Req_valid_a = ($urandom_range(0, 9) < 6);
      Req_addr_a  = 5'($urandom_range(0, 7));
      Req_data_a  = $urandom;
      Req_valid_m = ($urandom_range(0, 9) < 6);
      Req_addr_m  = 5'($urandom_range(0, 7));
      Req_data_m  = $urandom;
      Lookup_addr = 5'($urandom_range(0, 7));
      #1;
      n_checks++;
      if ({Req_ready_a, Req_ready_m} !== {m_ready_a(), m_ready_m()}) begin
        n_fail++;
        $display("FAIL rnd_ready i=%0d got=%b exp=%b", i,
                 {Req_ready_a, Req_ready_m}, {m_ready_a(), m_ready_m()});
      end
      n_checks++;
      if ({Write_En, Write_addr, Write_data}
          !== {o_we, o_addr, o_data}) begin
        n_fail++;
        $display("FAIL rnd_write i=%0d got=%0d/%0d/%0h exp=%0d/%0d/%0h",
                 i, Write_En, Write_addr, Write_data,
                 o_we, o_addr, o_data);
      end
      exp_l = model_lookup(Lookup_addr);
      n_checks++;
      if ({Lookup_hit, Lookup_data} !== exp_l) begin
        n_fail++;
        $display("FAIL rnd_lookup i=%0d a=%0d got=%b/%0h exp=%b/%0h",
                 i, Lookup_addr, Lookup_hit, Lookup_data,
                 exp_l[DATA_W], exp_l[DATA_W-1:0]);
      end
      tick();
    end
    Reset = 0;
    idle_inputs();
    tick();
  endtask

  initial begin
    test_reset();
    test_single();
    test_same_cycle();
    test_r0();
    test_age_override();
    test_stream();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/regfile_write_arbiter.md
# regfile_write_arbiter

Shares the single write port of the 32×32 register file between two writeback requesters: A (ALU result path) and M (memory/multicycle path). Each requester gets a one-entry holding slot with a valid/ready handshake. One slot per cycle is drained into registered `Write_En`/`Write_addr`/`Write_data` outputs that connect directly to the register file. A combinational lookup port exposes in-flight values so hazard/forwarding logic can bypass writes that have not yet landed.

## Interface
- `DATA_W`, 32, write data width
- `ADDR_W`, 5, register address width (32 registers; register 0 hardwired zero)

Ports:
- `Clock`  in  1  single clock; all state updates on rising edge
- `Reset`  in  1  synchronous, active-high reset
- `Req_valid_a`  in  1  requester A has a write
- `Req_addr_a`  in  ADDR_W  destination register for A
- `Req_data_a`  in  DATA_W  write data for A
- `Req_ready_a`  out  1  A's slot can accept this cycle
- `Req_valid_m`, `Req_addr_m`, `Req_data_m`, `Req_ready_m`  same as A, for requester M
- `Write_En`  out  1  register file write enable (registered)
- `Write_addr`  out  ADDR_W  register file write address (registered)
- `Write_data`  out  DATA_W  register file write data (registered)
- `Lookup_addr`  in  ADDR_W  forwarding query address
- `Lookup_hit`  out  1  youngest in-flight write to `Lookup_addr` exists
- `Lookup_data`  out  DATA_W  data of that youngest write; 0 when no hit

## Operation
- Reset: both slots empty, age bit cleared, RR pointer = A, `Write_En`=0, `Write_addr`=0, `Write_data`=0. `Req_ready_*` = 0 while `Reset` is high and 1 on the first cycle after.
- Handshake: a request is accepted on the rising edge where valid && ready. `Req_ready_x` = !slot_x_valid || grant_x (pass-through while the slot is draining).
- Writes to register 0: accepted (ready behaves as normal), discarded, never load a slot, never produce `Write_En`.
- Arbitration each cycle among valid slots:
  - Only one slot valid: grant it.
  - Both valid, same address, loaded in different cycles: the older slot wins, per the age bit, regardless of policy.
  - Both loaded in the same cycle with the same address: grant M first, so A's value persists.
  - Otherwise: policy (see Configuration).
- Grant at edge t: the slot contents move to the output registers and the slot is freed. `Write_En`=1 during cycle t..t+1. `Write_En` drops to 0 at the next edge if there is no grant.
- Age bit: set to the requester that loaded earlier. Recomputed whenever a slot loads or drains.
- Lookup (combinational): candidates are the two slots and the output stage when `Write_En`=1. Younger wins. Order, youngest first: the younger slot, then the older slot, then the output stage. `Lookup_addr`=0 → hit=0, data=0.
- Reset asserted mid-operation: pending slot contents are dropped, and `Write_En` goes to 0 at that edge.

## Timing
- Latency: acceptance at edge t0 → earliest grant at edge t0+1 → `Write_En` high in the cycle after t0+1 → register file captures at edge t0+2.
- Throughput: 1 write/cycle sustained. Both requesters streaming share it 1:1 with round-robin enabled.
- Lookup path is purely combinational from `Lookup_addr` and state. No added latency.
- `Req_ready_x` depends combinationally on slot state and grant, not on `Req_valid_x`.

## Configuration
- `WB_ARB_RR_EN` defined: round-robin policy. After A is granted, the pointer moves to M, and vice versa. A contested cycle grants the pointer side. Neither requester starves.
- `WB_ARB_RR_EN` undefined: fixed priority, M over A. A may starve under continuous M traffic. There is no pointer register.
- Both builds apply the same-address age override.

## Structure
- Package `regfile_arb_pkg`:
  - `DATA_W`, `ADDR_W`
  - `req_id_t` enum: `REQ_A`, `REQ_M`
  - `wb_slot_t` struct: valid, addr, data
- Sub-module `wb_slot`: a one-entry holding register with load/drain/flush controls, instantiated once per requester.
- Arbiter, age bit, output stage and lookup mux live in the top module.

## Test plan
- Reset then A writes r1=6 alone → `Write_En`=1, `Write_addr`=1, `Write_data`=6 two edges after acceptance; M idle with `Req_ready_m`=1.
- A and M request r3=7 and r4=9 in the same cycle → two consecutive writes, M first (fixed), or pointer side first (RR), with no bubble.
- A writes r0=7 → accepted, no `Write_En`; lookup of r0 returns hit=0, data=0.
- A writes r5=1, then next cycle M writes r5=2 while A's slot is blocked → r5=1 written before r5=2; lookup r5 returns 2 while both are pending.
- Both streaming continuously for 8 cycles with `WB_ARB_RR_EN` → exactly 4 grants each, alternating. Without the macro → 8 M grants, A ready held low.
- Reset asserted with both slots full → no `Write_En` next cycle; lookup of the previously held addresses returns hit=0.
